// File: rtl/single_to_fix_seq.sv
// Sequential IEEE-754 single -> unsigned Q(INT_WIDTH.FRACT_WIDTH) converter.
// Specials resolve at the accept edge; normal values go through a 1-bit/cycle shifter.
module single_to_fix_seq #(
    parameter int INT_WIDTH   = 12,
    parameter int FRACT_WIDTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [31:0]                      in_single,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [INT_WIDTH+FRACT_WIDTH-1:0] out_fixed,
    output logic                             out_ovf,
    output logic                             out_unf,
    output logic                             out_neg,
    output logic                             out_nan
);

    localparam int W  = INT_WIDTH + FRACT_WIDTH;
    localparam int RW = 24 + W;
    localparam logic signed [10:0] FRACT_S = 11'(FRACT_WIDTH);
    localparam logic signed [10:0] W_M1_S  = 11'(W - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   r_q, r_d;
    logic [5:0]      cnt_q, cnt_d;
    logic            dir_left_q, dir_left_d;
    logic [W-1:0]    fixed_q, fixed_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic            neg_q, neg_d;
    logic            nan_q, nan_d;

    logic                sgn;
    logic [7:0]          exp_f;
    logic [22:0]         man;
    logic signed [10:0]  p_s;
    logic signed [10:0]  k_s;
    logic                accept;
    logic                is_special;

    assign sgn    = in_single[31];
    assign exp_f  = in_single[30:23];
    assign man    = in_single[22:0];
    assign p_s    = $signed({3'b000, exp_f}) - 11'sd127 + FRACT_S;
    assign k_s    = p_s - 11'sd23;
    assign accept = in_valid && (state_q == IDLE);

    // Anything that is not a finite, in-range, positive normal skips the shifter.
    assign is_special = (exp_f == 8'hFF) || (sgn && (exp_f != 8'h00 || man != 23'h0)) ||
                        (exp_f == 8'h00) || (p_s > W_M1_S) || (p_s < 11'sd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = is_special ? DONE : SHIFT;
            SHIFT:   if (cnt_q == 6'd0) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q        <= '0;
            cnt_q      <= '0;
            dir_left_q <= 1'b0;
            fixed_q    <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            neg_q      <= 1'b0;
            nan_q      <= 1'b0;
        end else begin
            r_q        <= r_d;
            cnt_q      <= cnt_d;
            dir_left_q <= dir_left_d;
            fixed_q    <= fixed_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            neg_q      <= neg_d;
            nan_q      <= nan_d;
        end
    end

    always_comb begin
        r_d        = r_q;
        cnt_d      = cnt_q;
        dir_left_d = dir_left_q;
        fixed_d    = fixed_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        neg_d      = neg_q;
        nan_d      = nan_q;
        if (accept) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
            neg_d = 1'b0;
            nan_d = 1'b0;
            if (exp_f == 8'hFF && man != 23'h0) begin
                fixed_d = '0;
                nan_d   = 1'b1;
            end else if (sgn && (exp_f != 8'h00 || man != 23'h0)) begin
                fixed_d = '0;
                neg_d   = 1'b1;
            end else if (exp_f == 8'h00 && man == 23'h0) begin
                fixed_d = '0;
            end else if (exp_f == 8'h00) begin
                fixed_d = '0;
                unf_d   = 1'b1;
            end else if (exp_f == 8'hFF || p_s > W_M1_S) begin
                fixed_d = '1;
                ovf_d   = 1'b1;
            end else if (p_s < 11'sd0) begin
                fixed_d = '0;
                unf_d   = 1'b1;
            end else begin
                r_d        = {{W{1'b0}}, 1'b1, man};
                cnt_d      = 6'(k_s < 11'sd0 ? -k_s : k_s);
                dir_left_d = (k_s > 11'sd0);
            end
        end else if (state_q == SHIFT) begin
            // Truncating shift: bits falling off the right end are simply lost.
            if (cnt_q == 6'd0) begin
                fixed_d = r_q[W-1:0];
            end else begin
                r_d   = dir_left_q ? {r_q[RW-2:0], 1'b0} : {1'b0, r_q[RW-1:1]};
                cnt_d = cnt_q - 6'd1;
            end
        end
    end

    assign out_fixed = fixed_q;
    assign out_ovf   = ovf_q;
    assign out_unf   = unf_q;
    assign out_neg   = neg_q;
    assign out_nan   = nan_q;

endmodule

// File: tb/tb_single_to_fix_seq.sv
// Directed self-checking bench for single_to_fix_seq (W = 16, Q12.4).
// Each test task drives its own vectors and compares against hand-computed values.
module tb_single_to_fix_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_single;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_fixed;
    logic        out_ovf;
    logic        out_unf;
    logic        out_neg;
    logic        out_nan;

    int nCompared;
    int nMismatched;

    single_to_fix_seq #(.INT_WIDTH(12), .FRACT_WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_single (in_single),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_fixed (out_fixed),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf),
        .out_neg   (out_neg),
        .out_nan   (out_nan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one input, returns edges counted after the accept edge until out_valid.
    task automatic applyStimulus(input logic [31:0] val, output int edges);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        in_single = val;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_single = 32'hDEADBEEF;
        edges = 0;
        while (!out_valid && edges < 64) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic ackResult();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        nCompared++;
        if ({in_ready, out_valid} !== 2'b10) begin
            nMismatched++;
            $display("[TB] FAIL reset_handshake got in_ready/out_valid=%b want 10", {in_ready, out_valid});
        end
        nCompared++;
        if ({out_fixed, out_ovf, out_unf, out_neg, out_nan} !== 20'h0) begin
            nMismatched++;
            $display("[TB] FAIL reset_outputs got fixed=%h flags=%b want 0000/0000", out_fixed,
                     {out_ovf, out_unf, out_neg, out_nan});
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_normal();
        logic [31:0] vin  [5] = '{32'h3F800000, 32'h40200000, 32'h457FFF00, 32'h3D800000, 32'h3F8C0000};
        logic [15:0] vexp [5] = '{16'h0010, 16'h0028, 16'hFFFF, 16'h0001, 16'h0011};
        int          vlat [5] = '{20, 19, 9, 24, 20};
        int edges;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vin[i], edges);
            nCompared++;
            if (edges !== vlat[i]) begin
                nMismatched++;
                $display("[TB] FAIL normal_latency[%0h] got %0d edges want %0d", vin[i], edges, vlat[i]);
            end
            nCompared++;
            if (out_fixed !== vexp[i]) begin
                nMismatched++;
                $display("[TB] FAIL normal_value[%0h] got %h want %h", vin[i], out_fixed, vexp[i]);
            end
            nCompared++;
            if ({out_ovf, out_unf, out_neg, out_nan} !== 4'b0000) begin
                nMismatched++;
                $display("[TB] FAIL normal_flags[%0h] got %b want 0000", vin[i],
                         {out_ovf, out_unf, out_neg, out_nan});
            end
            ackResult();
        end
    endtask

    task automatic test_specials();
        // Flags ordered {ovf, unf, neg, nan}.
        logic [31:0] vin   [8] = '{32'h45800000, 32'h7F800000, 32'h3D000000, 32'hBF800000,
                                   32'hFF800000, 32'h7FC00000, 32'h80000000, 32'h00000001};
        logic [15:0] vexp  [8] = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000,
                                   16'h0000, 16'h0000, 16'h0000, 16'h0000};
        logic [3:0]  vflag [8] = '{4'b1000, 4'b1000, 4'b0100, 4'b0010,
                                   4'b0010, 4'b0001, 4'b0000, 4'b0100};
        int edges;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vin[i], edges);
            nCompared++;
            if (edges !== 0) begin
                nMismatched++;
                $display("[TB] FAIL special_latency[%0h] got %0d edges want 0", vin[i], edges);
            end
            nCompared++;
            if (out_fixed !== vexp[i]) begin
                nMismatched++;
                $display("[TB] FAIL special_value[%0h] got %h want %h", vin[i], out_fixed, vexp[i]);
            end
            nCompared++;
            if ({out_ovf, out_unf, out_neg, out_nan} !== vflag[i]) begin
                nMismatched++;
                $display("[TB] FAIL special_flags[%0h] got %b want %b", vin[i],
                         {out_ovf, out_unf, out_neg, out_nan}, vflag[i]);
            end
            ackResult();
        end
    endtask

    task automatic test_backpressure();
        int edges;
        applyStimulus(32'h40200000, edges);
        in_valid  = 1'b1;
        in_single = 32'h3F800000;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            nCompared++;
            if ({out_valid, in_ready, out_fixed} !== {2'b10, 16'h0028}) begin
                nMismatched++;
                $display("[TB] FAIL backpressure_hold[%0d] got valid/ready=%b%b fixed=%h want 10/0028", c,
                         out_valid, in_ready, out_fixed);
            end
        end
        in_valid = 1'b0;
        ackResult();
        nCompared++;
        if ({out_valid, in_ready} !== 2'b01) begin
            nMismatched++;
            $display("[TB] FAIL backpressure_release got valid/ready=%b%b want 01", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_shift();
        int edges;
        @(negedge clk);
        in_single = 32'h3F800000;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        nCompared++;
        if ({out_valid, in_ready, out_fixed} !== {2'b01, 16'h0000}) begin
            nMismatched++;
            $display("[TB] FAIL midshift_reset got valid/ready=%b%b fixed=%h want 01/0000",
                     out_valid, in_ready, out_fixed);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(32'h40200000, edges);
        nCompared++;
        if ({out_valid, out_fixed} !== {1'b1, 16'h0028}) begin
            nMismatched++;
            $display("[TB] FAIL midshift_recover got valid=%b fixed=%h want 1/0028", out_valid, out_fixed);
        end
        nCompared++;
        if (edges !== 19) begin
            nMismatched++;
            $display("[TB] FAIL midshift_latency got %0d edges want 19", edges);
        end
        ackResult();
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        rst         = 1'b0;
        in_valid    = 1'b0;
        in_single   = 32'h0;
        out_ready   = 1'b0;
        #2;
        test_reset();
        test_normal();
        test_specials();
        test_backpressure();
        test_reset_mid_shift();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
